mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 180 ++++++++++++++++++
 tb/tb_mem_responder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port word memory behind a request/response handshake with a fixed,
// parameterised response latency. Accepts one request at a time; byte and
// halfword writes merge into the addressed word, reads return the full word.
module mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Req,
  input  logic [31:0] Adr,
  input  logic        WE,
  input  logic [31:0] WD,
  input  logic [1:0]  ByteAccess,
  output logic        Busy,
  output logic        Ready,
  output logic [31:0] RD,
  output logic        Err
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wd_q, wd_d;
  logic        we_q, we_d;
  logic [1:0]  ba_q, ba_d;
  logic [31:0] rd_q, rd_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic [31:0] cur_adr, cur_wd;
  logic        cur_we;
  logic [1:0]  cur_ba;
  logic        misalign, out_of_range, cur_err;
  logic [AW-1:0] cur_idx;
  logic [3:0]  lane_en;
  logic [31:0] wdata;
  logic        enter_resp;
  logic        commit;

  // Effective request: live inputs on the accepting edge (needed when
  // LATENCY = 1 commits on that same edge), captured copy afterwards.
  always_comb begin
    if (state_q == IDLE) begin
      cur_adr = Adr;
      cur_wd  = WD;
      cur_we  = WE;
      cur_ba  = ByteAccess;
    end else begin
      cur_adr = adr_q;
      cur_wd  = wd_q;
      cur_we  = we_q;
      cur_ba  = ba_q;
    end
  end

  // Error classification, word index and lane enables for the effective request
  always_comb begin
    misalign = 1'b0;
    lane_en  = '0;
    wdata    = cur_wd;
    case (cur_ba)
      2'b00: begin
        misalign = (cur_adr[1:0] != 2'b00);
        lane_en  = 4'b1111;
      end
      2'b01: begin
        misalign = cur_adr[0];
        lane_en  = cur_adr[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{cur_wd[15:0]}};
      end
      2'b10: begin
        lane_en  = 4'b0001 << cur_adr[1:0];
        wdata    = {4{cur_wd[7:0]}};
      end
      default: misalign = 1'b1;
    endcase
    out_of_range = ({2'b00, cur_adr[31:2]} >= 32'(DEPTH));
    cur_err      = misalign | out_of_range;
    cur_idx      = cur_adr[AW+1:2];
  end

  // FSM, latency counter, request capture and response formation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    adr_d      = adr_q;
    wd_d       = wd_q;
    we_d       = we_q;
    ba_d       = ba_q;
    rd_d       = '0;
    err_d      = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (Req) begin
          adr_d = Adr;
          wd_d  = WD;
          we_d  = WE;
          ba_d  = ByteAccess;
          cnt_d = CNT_LOAD;
          if (LATENCY <= 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Leave when the decremented count reaches zero, so RESP lands
        // exactly LATENCY cycles after acceptance.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      err_d = cur_err;
      if (!cur_we && !cur_err) begin
        rd_d = mem[cur_idx];
      end
    end
  end

  assign commit = enter_resp && cur_we && !cur_err;

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      ba_q    <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      ba_q    <= ba_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  // Storage: lane-masked write on the edge entering RESP; reset blocks it
  always_ff @(posedge CLK) begin
    if (Reset && commit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lane_en[i]) begin
          mem[cur_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign Busy  = (state_q != IDLE);
  assign Ready = (state_q == RESP);
  assign RD    = rd_q;
  assign Err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=2 instance for functional
// behaviour, LATENCY=3 instance for back-to-back acceptance timing.
module tb_mem_responder;

  localparam int unsigned LAT = 2;

  logic        CLK;
  logic        Reset, Req, WE;
  logic [31:0] Adr, WD;
  logic [1:0]  ByteAccess;
  logic        Busy, Ready, Err;
  logic [31:0] RD;

  logic        rst3_n, req3, we3;
  logic [31:0] adr3, wd3;
  logic [1:0]  ba3;
  logic        busy3, ready3, err3;
  logic [31:0] rd3;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  mem_responder #(.DEPTH(1024), .LATENCY(LAT)) dut (
    .CLK(CLK), .Reset(Reset), .Req(Req), .Adr(Adr), .WE(WE), .WD(WD),
    .ByteAccess(ByteAccess), .Busy(Busy), .Ready(Ready), .RD(RD), .Err(Err)
  );

  mem_responder #(.DEPTH(64), .LATENCY(3)) dut3 (
    .CLK(CLK), .Reset(rst3_n), .Req(req3), .Adr(adr3), .WE(we3), .WD(wd3),
    .ByteAccess(ba3), .Busy(busy3), .Ready(ready3), .RD(rd3), .Err(err3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in an IDLE cycle; returns at the negedge after Ready.
  task automatic xact(input string tag, input logic we, input logic [31:0] adr,
                      input logic [31:0] wd, input logic [1:0] ba,
                      input logic [31:0] exp_rd, input logic exp_err);
    int unsigned n;
    chk({tag, " idle"}, {31'd0, Busy}, 32'd0);
    Req = 1'b1; WE = we; Adr = adr; WD = wd; ByteAccess = ba;
    @(posedge CLK);
    @(negedge CLK);
    // Scramble inputs: the DUT must use its captured copy
    Req = 1'b0; WE = ~we; Adr = 32'hFFFF_FFFF; WD = 32'h5A5A_5A5A; ByteAccess = 2'b11;
    n = 1;
    while (Ready !== 1'b1 && n < 8) begin
      chk({tag, " wait busy"}, {31'd0, Busy}, 32'd1);
      chk({tag, " wait rd"}, RD, 32'd0);
      @(negedge CLK);
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(LAT));
    chk({tag, " rd"}, RD, exp_rd);
    chk({tag, " err"}, {31'd0, Err}, {31'd0, exp_err});
    @(negedge CLK);
    chk({tag, " ready pulse"}, {31'd0, Ready}, 32'd0);
    chk({tag, " busy after"}, {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    Reset = 1'b0; Req = 1'b1; WE = 1'b1; Adr = 32'h10; WD = 32'h99; ByteAccess = 2'b00;
    rst3_n = 1'b0; req3 = 1'b0; we3 = 1'b1; adr3 = 32'h0; wd3 = 32'h1; ba3 = 2'b00;

    // Reset with Req asserted: nothing accepted, outputs quiet
    repeat (3) @(negedge CLK);
    chk("reset busy", {31'd0, Busy}, 32'd0);
    chk("reset ready", {31'd0, Ready}, 32'd0);
    chk("reset rd", RD, 32'd0);
    chk("reset err", {31'd0, Err}, 32'd0);
    Req = 1'b0;
    Reset = 1'b1;

    // Word write then read
    xact("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 32'h0, 1'b0);
    xact("rd10", 1'b0, 32'h10, 32'h0, 2'b00, 32'hDEADBEEF, 1'b0);

    // Byte and halfword lane merges (upper WD bits must be ignored)
    xact("wr20", 1'b1, 32'h20, 32'h0, 2'b00, 32'h0, 1'b0);
    xact("wb22", 1'b1, 32'h22, 32'hFFFF_FFAB, 2'b10, 32'h0, 1'b0);
    xact("rd20a", 1'b0, 32'h20, 32'h0, 2'b00, 32'h00AB0000, 1'b0);
    xact("wh20", 1'b1, 32'h20, 32'hFFFF_1234, 2'b01, 32'h0, 1'b0);
    xact("rd20b", 1'b0, 32'h20, 32'h0, 2'b00, 32'h00AB1234, 1'b0);

    // Misaligned / illegal accesses
    xact("wh21", 1'b1, 32'h21, 32'h0000_9999, 2'b01, 32'h0, 1'b1);
    xact("rd20c", 1'b0, 32'h20, 32'h0, 2'b00, 32'h00AB1234, 1'b0);
    xact("ba11", 1'b0, 32'h20, 32'h0, 2'b11, 32'h0, 1'b1);
    xact("ww22", 1'b1, 32'h22, 32'hFFFF_FFFF, 2'b00, 32'h0, 1'b1);
    xact("rd20d", 1'b0, 32'h20, 32'h0, 2'b00, 32'h00AB1234, 1'b0);

    // Upper lanes
    xact("wb23", 1'b1, 32'h23, 32'h0000_0077, 2'b10, 32'h0, 1'b0);
    xact("rd20e", 1'b0, 32'h20, 32'h0, 2'b00, 32'h77AB1234, 1'b0);
    xact("wh22", 1'b1, 32'h22, 32'hABCD_5678, 2'b01, 32'h0, 1'b0);
    xact("rd20f", 1'b0, 32'h20, 32'h0, 2'b00, 32'h56781234, 1'b0);

    // Range boundary: last word legal, first word past the end illegal
    xact("wrFFC", 1'b1, 32'hFFC, 32'hCAFEF00D, 2'b00, 32'h0, 1'b0);
    xact("rdFFC", 1'b0, 32'hFFC, 32'h0, 2'b00, 32'hCAFEF00D, 1'b0);
    xact("rd1000", 1'b0, 32'h1000, 32'h0, 2'b00, 32'h0, 1'b1);
    xact("wr1000", 1'b1, 32'h1000, 32'h1, 2'b00, 32'h0, 1'b1);

    // Req raised in WAIT and held through RESP is dropped
    Req = 1'b1; WE = 1'b0; Adr = 32'h10; ByteAccess = 2'b00;
    @(posedge CLK);
    @(negedge CLK);
    WE = 1'b1; WD = 32'h0; Adr = 32'h10;
    chk("drop wait busy", {31'd0, Busy}, 32'd1);
    chk("drop wait ready", {31'd0, Ready}, 32'd0);
    @(negedge CLK);
    chk("drop resp ready", {31'd0, Ready}, 32'd1);
    chk("drop resp busy", {31'd0, Busy}, 32'd1);
    chk("drop resp rd", RD, 32'hDEADBEEF);
    @(negedge CLK);
    Req = 1'b0;
    chk("drop idle busy", {31'd0, Busy}, 32'd0);
    chk("drop idle ready", {31'd0, Ready}, 32'd0);
    xact("rd10b", 1'b0, 32'h10, 32'h0, 2'b00, 32'hDEADBEEF, 1'b0);

    // Reset mid-operation aborts the pending write
    xact("wr30", 1'b1, 32'h30, 32'h0BADF00D, 2'b00, 32'h0, 1'b0);
    Req = 1'b1; WE = 1'b1; Adr = 32'h30; WD = 32'h55; ByteAccess = 2'b00;
    @(posedge CLK);
    @(negedge CLK);
    Req = 1'b0;
    chk("abort wait busy", {31'd0, Busy}, 32'd1);
    Reset = 1'b0;
    @(negedge CLK);
    Reset = 1'b1;
    chk("abort busy", {31'd0, Busy}, 32'd0);
    chk("abort ready", {31'd0, Ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("abort no ready", {31'd0, Ready}, 32'd0);
    end
    xact("rd30", 1'b0, 32'h30, 32'h0, 2'b00, 32'h0BADF00D, 1'b0);

    // LATENCY=3, Req held high: accept T, T+4, T+8; Ready at T+3, T+7, T+11
    rst3_n = 1'b1; req3 = 1'b1;
    chk("l3 idle busy", {31'd0, busy3}, 32'd0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      chk($sformatf("l3 busy c%0d", k), {31'd0, busy3}, ((k % 4) == 0) ? 32'd0 : 32'd1);
      chk($sformatf("l3 ready c%0d", k), {31'd0, ready3}, ((k % 4) == 3) ? 32'd1 : 32'd0);
      chk($sformatf("l3 err c%0d", k), {31'd0, err3}, 32'd0);
      chk($sformatf("l3 rd c%0d", k), rd3, 32'd0);
    end
    req3 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
